// File: rtl/instr_fetch.sv
// instr_fetch: RV32I instruction-fetch stage.
// Owns the PC, addresses a combinational instruction ROM, buffers returned
// words in a small circular fetch queue and presents {pc, instr} to decode
// through a valid/ready handshake. EX redirects flush the queue and restart
// fetch at the (word-aligned) target.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] fetch_count
);

  // Pointer width covers QDEPTH entries; count needs one more bit so that
  // "full" (count == QDEPTH) is distinguishable from "empty".
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      fetch_count_q, fetch_count_d;

  // Queue storage: one {pc, instr} pair per entry.
  logic [31:0]      qpc_q   [QDEPTH];
  logic [31:0]      qinstr_q[QDEPTH];

  // ---------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------
  logic        not_full;
  logic        push;
  logic        pop;
  logic [31:0] redirect_target;

  // Low two bits of the target are ignored; masking keeps fetch word-aligned.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  assign not_full = (count_q < DEPTH_C);

  // A redirect hides the head immediately so decode never consumes a
  // wrong-path instruction in the flush cycle.
  assign id_valid = (count_q != '0) && !redirect_valid;
  assign pop      = id_valid && id_ready;

  // Pushing while full is allowed when the head leaves in the same cycle,
  // which keeps a full queue streaming at one instruction per cycle.
  assign push     = !redirect_valid && (not_full || pop);

  // ---------------------------------------------------------------------
  // Next-state logic for PC, pointers, occupancy and fetch counter
  // ---------------------------------------------------------------------
  // Next-state computation; redirect overrides every other update.
  always_comb begin
    pc_d          = pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    fetch_count_d = fetch_count_q;

    if (redirect_valid) begin
      pc_d     = redirect_target;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d          = pc_q + 32'd4;
        wr_ptr_d      = wr_ptr_q + PTR_W'(1);
        fetch_count_d = fetch_count_q + 32'd1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers: PC, queue pointers, occupancy and fetch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Queue entries
  // ---------------------------------------------------------------------
  // Entries are cleared on reset so the head outputs read as zero while
  // reset is held; a redirect only rewinds the pointers, stale contents
  // are simply overwritten later.
  generate
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
      logic wr_en;
      assign wr_en = push && (wr_ptr_q == PTR_W'(gi));

      // Capture {pc, word} into this entry when it is the write target.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          qpc_q[gi]    <= '0;
          qinstr_q[gi] <= '0;
        end else if (wr_en) begin
          qpc_q[gi]    <= pc_q;
          qinstr_q[gi] <= imem_rdata;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign imem_addr   = pc_q;
  assign id_instr    = qinstr_q[rd_ptr_q];
  assign id_pc       = qpc_q[rd_ptr_q];
  assign id_pc_plus4 = id_pc + 32'd4;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch.
// The stimulus process owns the expected instruction stream: every time it
// starts a stream (reset release or redirect) it flushes the expected queue
// and keeps it topped up with consecutive word addresses from the target.
// An independent monitor pops and compares on every decode handshake.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] fetch_count;

  instr_fetch #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction ROM contents as a pure function of the byte address;
  // address 0 holds 32'h00A00213.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00A0_0213;
  endfunction

  assign imem_rdata = rom(imem_addr);

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Keep enough expected addresses queued for the monitor.
  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  // Start a new expected stream at the word-aligned target.
  task automatic flush_to(input logic [31:0] t);
    exp_q.delete();
    gen_pc = t & 32'hFFFF_FFFC;
    refill();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    refill();
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  bit prev_block = 1'b1;
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst_n) begin
      prev_block = 1'b1;
    end else begin
      if (redirect_valid)
        check("valid_hidden_on_redirect", 32'(id_valid), 32'd0);
      else if (!prev_block)
        check("no_bubble", 32'(id_valid), 32'd1);
      if (id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_delivery: got pc %h, expected nothing", id_pc);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] deliver pc=%h instr=%h (expect pc=%h)", id_pc, id_instr, e);
          check("id_pc", id_pc, e);
          check("id_instr", id_instr, rom(e));
          check("id_pc_plus4", id_pc_plus4, e + 32'd4);
        end
      end
      prev_block = redirect_valid;
    end
  end

  // Stimulus.
  initial begin
    logic [31:0] t;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    id_ready       = 1'b0;
    gen_pc         = RESET_PC;

    // Reset state.
    #2;
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_instr", id_instr, 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_id_pc_plus4", id_pc_plus4, 32'd4);
    check("rst_fetch_count", fetch_count, 32'd0);
    step();
    step();

    // 1: release with ready high; first word one cycle later.
    id_ready = 1'b1;
    flush_to(RESET_PC);
    rst_n = 1'b1;
    step();
    check("t1_valid", 32'(id_valid), 32'd1);
    check("t1_pc", id_pc, 32'd0);
    check("t1_instr", id_instr, 32'h00A0_0213);
    repeat (4) step();

    // 2: stall from reset; queue fills, fetch address holds.
    rst_n = 1'b0;
    step();
    id_ready = 1'b0;
    flush_to(RESET_PC);
    rst_n = 1'b1;
    repeat (5) step();
    check("t2_imem_addr_hold", imem_addr, 32'h0000_0008);
    check("t2_fetch_count", fetch_count, 32'd2);
    id_ready = 1'b1;
    repeat (6) step();

    // 3: redirect to an unaligned target while the queue is full.
    id_ready = 1'b0;
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0039;
    flush_to(32'h0000_0039);
    #1;
    check("t3_valid_low", 32'(id_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    repeat (6) step();

    // 4: back-to-back redirects with a stalled head.
    id_ready = 1'b0;
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1234;
    flush_to(32'h0000_1234);
    step();
    redirect_pc = 32'h0000_0040;
    flush_to(32'h0000_0040);
    step();
    redirect_valid = 1'b0;
    repeat (3) step();
    id_ready = 1'b1;
    repeat (6) step();

    // 5: PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    flush_to(32'hFFFF_FFFC);
    step();
    redirect_valid = 1'b0;
    step();
    check("t5_pc_top", id_pc, 32'hFFFF_FFFC);
    check("t5_plus4_wrap", id_pc_plus4, 32'h0000_0000);
    step();
    check("t5_pc_wrapped", id_pc, 32'h0000_0000);
    repeat (3) step();

    // 6: asynchronous reset mid-stream with the queue full.
    id_ready = 1'b0;
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_valid_async", 32'(id_valid), 32'd0);
    check("t6_imem_addr_async", imem_addr, RESET_PC);
    check("t6_fetch_count_async", fetch_count, 32'd0);
    check("t6_id_instr_async", id_instr, 32'd0);
    step();
    flush_to(RESET_PC);
    rst_n    = 1'b1;
    id_ready = 1'b1;
    repeat (5) step();

    // Randomized traffic: stalls, redirects (some near the wrap) and resets.
    repeat (800) begin
      id_ready = (($urandom % 4) != 0);
      if (($urandom % 200) == 0) begin
        redirect_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        $display("[TB] reset pulse");
        step();
        flush_to(RESET_PC);
        rst_n = 1'b1;
      end else if (($urandom % 12) == 0) begin
        t = (($urandom % 6) == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : $urandom;
        redirect_valid = 1'b1;
        redirect_pc    = t;
        flush_to(t);
        $display("[TB] redirect to %h", t);
      end else begin
        redirect_valid = 1'b0;
      end
      step();
    end

    redirect_valid = 1'b0;
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog: the stimulus is fixed-length, this only guards against a hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
